// File: rtl/object_vertical_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pong_pkg
//  Description : Shared constants and helpers for the moving-object counters:
//                terminal count, vertical window threshold, parameter checks.
//  Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

  // Terminal count of a WIDTH-bit up counter (all ones).
  function automatic int unsigned tc(input int unsigned width);
    return 32'((64'd1 << width) - 64'd1);
  endfunction

  // First count at which the object's vertical window opens.
  function automatic int unsigned win_lo(input int unsigned width,
                                         input int unsigned size);
    return 32'((64'd1 << width) - 64'(size));
  endfunction

  // Legal parameter set: reload narrower than the counter, height a power
  // of two, and no reload value can land inside the window.
  function automatic bit params_ok(input int unsigned width,
                                   input int unsigned mw,
                                   input int unsigned size);
    longint unsigned span;
    longint unsigned mspan;
    span  = 64'd1 << width;
    mspan = 64'd1 << mw;
    return (width >= 2) && (width <= 31) && (mw >= 1) && (mw < width) &&
           (size >= 1) && ((size & (size - 1)) == 0) &&
           (64'(size) <= span - mspan);
  endfunction

endpackage
`default_nettype wire

// File: rtl/object_vertical_counter_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge
//  Description : Registered edge detector for a clk-synchronous level. The
//                previous-sample register resets to RESET_VAL so an input that
//                idles at that level produces no edge right after reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_edge #(
  parameter logic RESET_VAL = 1'b1,
  parameter bit   RISING    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_edge
);

  logic r_d;

  // Previous sample of the input level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d <= RESET_VAL;
    end else begin
      r_d <= i_d;
    end
  end

  generate
    if (RISING) begin : g_rise
      assign o_edge = i_d & ~r_d;
    end else begin : g_fall
      assign o_edge = ~i_d & r_d;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/object_vertical_counter.sv
`default_nettype none
// ============================================================================
//  Module      : object_vertical_counter
//  Description : Vertical line counter for one moving object. Counts _hsync
//                rises during active display, reloads from a motion value
//                latched at vblank entry, and decodes the vertical window.
//  Revision    : 1.0 - initial release
// ============================================================================
module object_vertical_counter
  import pong_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MW    = 4,
  parameter int SIZE  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             _hsync,
  input  logic             _vblank,
  input  logic             freeze,
  input  logic [MW-1:0]    motion,
  output logic [WIDTH-1:0] vpos,
  output logic             vball_tc,
  output logic             vvid,
  output logic             _vvid,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] C_TC     = WIDTH'(tc(WIDTH));
  localparam logic [WIDTH-1:0] C_WIN_LO = WIDTH'(win_lo(WIDTH, SIZE));

  generate
    if (!params_ok(WIDTH, MW, SIZE)) begin : g_param_check
      $error("object_vertical_counter: illegal WIDTH/MW/SIZE combination");
    end
  endgenerate

  logic             w_hs_rise;
  logic             w_vb_fall;
  logic             w_step;
  logic [WIDTH-1:0] r_count;
  logic [MW-1:0]    r_motion_q;
  logic             r_wrap;

  sync_edge #(.RESET_VAL(1'b1), .RISING(1'b1)) u_hs_edge (
    .clk    (clk),
    .rst    (reset),
    .i_d    (_hsync),
    .o_edge (w_hs_rise)
  );

  sync_edge #(.RESET_VAL(1'b1), .RISING(1'b0)) u_vb_edge (
    .clk    (clk),
    .rst    (reset),
    .i_d    (_vblank),
    .o_edge (w_vb_fall)
  );

  // A line is counted only during active display and when not frozen.
  assign w_step = w_hs_rise & _vblank & ~freeze;

  // Count lines, reload from the frame's latched motion at terminal count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_motion_q <= '0;
      r_wrap     <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (w_vb_fall) begin
        r_motion_q <= motion;
      end
      if (w_step) begin
        if (r_count == C_TC) begin
          r_count <= {{(WIDTH-MW){1'b0}}, r_motion_q};
          r_wrap  <= 1'b1;
        end else begin
          r_count <= r_count + 1'b1;
        end
      end
    end
  end

  assign vpos     = r_count;
  assign vball_tc = (r_count == C_TC);
  assign vvid     = (r_count >= C_WIN_LO);
  assign _vvid    = ~vvid;
  assign wrap     = r_wrap;

endmodule
`default_nettype wire
